formant_dp_pipe: RTL
====================

Name: formant_dp_pipe

Overview:
- Parametrised successor to the single-formant-row DP min stage of the formant tracker.
- For frame i it computes F(k,i) = min over j of [E(j+1,i) + F(k-1,j)] and backpointer B(k,i) for k = 1..min(i+1, k_max).
- Fully pipelined across k: no bubble between formant rows, one memory request per cycle.
- Sits between the Emin/F memories and the F/B writeback RAMs.

Parameters:
- BIT_WIDTH, 32, cost width; all-ones encodes infinity.
- I, 160, frames per utterance; i ranges 0..I-1.
- FORMANTS, 5, maximum formant count.
- MEM_LATENCY, 2, cycles from request to e_prev/f_prev valid; legal range 1..4.

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- begin_iter  in  1  start pulse; sampled only when busy=0
- i  in  $clog2(I)  frame index, latched on accepted begin_iter
- k_max  in  $clog2(FORMANTS+1)  runtime formant limit 1..FORMANTS, latched with i
- e_prev  in  BIT_WIDTH  E(j+1,i), valid MEM_LATENCY cycles after request
- f_prev  in  BIT_WIDTH  F(k-1,j), valid MEM_LATENCY cycles after request
- req_valid  out  1  request issued this cycle
- k_req  out  $clog2(FORMANTS+1)  requested k
- j_req  out  $clog2(I)+1  signed requested j, may be -1
- output_valid  out  1  one-cycle pulse per completed k
- k_write  out  $clog2(FORMANTS+1)  k of the current result
- f_data  out  BIT_WIDTH  F(k,i)
- b_data  out  $clog2(I)+1  signed argmin j
- busy  out  1  high from accepted begin_iter through the iter_done cycle
- iter_done  out  1  one-cycle pulse with the last output_valid

Behaviour:
- Reset is asynchronous. Outputs clear to 0 and the FSM goes to IDLE. An in-flight pipeline is discarded, and no output_valid or iter_done fires afterwards.
- FSM states: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE: on begin_iter, latch i and k_max, set kl = min(i+1, k_max), set k=1, j=-1, then enter ISSUE.
- ISSUE:
  - Every cycle: req_valid=1, k_req=k, j_req=j.
  - Start j is k-2, except k=1, which starts at -1.
  - When j==i-1: if k<kl, advance to k+1 and the new start j the next cycle (no idle cycle); otherwise go to DRAIN.
- Tag pipeline: depth MEM_LATENCY+1, carrying {valid, k, j, first, last}.
  - first marks the start j of a k row; last marks j==i-1.
- Compute stage (tag exits delay line):
  - cost = e_prev when k==1 and j==-1.
  - cost = infinity when k>1 and j==-1.
  - Otherwise cost = e_prev + f_prev, with the width rule under the optional feature.
  - An infinity operand always yields infinity.
  - If first: acc=cost and bp=j. Else if cost < acc (strict, lowest j wins ties): acc=cost and bp=j.
- Output:
  - One cycle after the compute stage of a last tag, drive output_valid=1, k_write=k, f_data=acc, b_data=bp.
  - Result latency = MEM_LATENCY+1 cycles after the last request of that row.
- DRAIN: when the final row's output_valid fires, also pulse iter_done; busy drops the next cycle.
- begin_iter while busy=1 is ignored (no queueing).
- begin_iter in the same cycle as iter_done is ignored, because busy is still 1.
- Boundaries:
  - i=0: one request (k=1, j=-1); f_data=E(0,0), b_data=-1.
  - k_max=0 is treated as 1.
  - An all-infinity row gives f_data=all-ones and b_data=start j.

Optional Feature:
- Macro: FDP_SAT_EN.
- Defined: the sum is formed in BIT_WIDTH+1 bits and clamps to all-ones on carry-out, so sums never wrap.
- Undefined: the sum truncates to BIT_WIDTH bits. Callers must keep costs below 2^(BIT_WIDTH-1).
- The infinity-operand rule applies in both builds.

Test Plan:
- i=0, k_max=5, e_prev=7 -> exactly 1 request (1,-1); output_valid at request+3 with k_write=1, f_data=7, b_data=-1; iter_done same cycle.
- i=3, k_max=5 -> requests row by row with no gaps: k=1 j=-1..2, k=2 j=0..2, k=3 j=1..2, k=4 j=2. That is 10 consecutive req_valid cycles, 4 output_valid pulses, iter_done on k=4.
- i=3, k=2, costs over j=0..2 are 9,4,4 -> f_data=4, b_data=1 (tie keeps lowest j).
- FDP_SAT_EN defined, e_prev=32'hFFFF0000, f_prev=32'h00020000 -> f_data=32'hFFFFFFFF. Undefined -> f_data=32'h00010000.
- i=10, k_max=2, with a second begin_iter mid-run -> exactly 2 output_valid pulses, the second begin_iter is ignored, and busy falls one cycle after iter_done.
- rst_n_in asserted low mid-ISSUE -> all outputs 0 immediately, no later output_valid; a new begin_iter after release runs normally.

Source files
------------

// File: rtl/formant_dp_pipe.sv
// Formant DP min stage: F(k,i) = min_j [E(j+1,i) + F(k-1,j)] with argmin backpointer, rows k = 1..min(i+1,k_max).
// Latency: one request per cycle, rows back to back; row result appears MEM_LATENCY+1 cycles after its last request.
// Backpressure: none; memories must answer in exactly MEM_LATENCY cycles. Optional FDP_SAT_EN makes the adder saturate.
module formant_dp_pipe #(
   parameter int BIT_WIDTH   = 32,
   parameter int I           = 160,
   parameter int FORMANTS    = 5,
   parameter int MEM_LATENCY = 2
) (
   input  logic                                clk_in,
   input  logic                                rst_n_in,
   input  logic                                begin_iter,
   input  logic [$clog2(I)-1:0]                i,
   input  logic [$clog2(FORMANTS+1)-1:0]       k_max,
   input  logic [BIT_WIDTH-1:0]                e_prev,
   input  logic [BIT_WIDTH-1:0]                f_prev,
   output logic                                req_valid,
   output logic [$clog2(FORMANTS+1)-1:0]       k_req,
   output logic signed [$clog2(I):0]           j_req,
   output logic                                output_valid,
   output logic [$clog2(FORMANTS+1)-1:0]       k_write,
   output logic [BIT_WIDTH-1:0]                f_data,
   output logic signed [$clog2(I):0]           b_data,
   output logic                                busy,
   output logic                                iter_done
);

   localparam int IW  = $clog2(I);
   localparam int IW1 = IW + 1;
   localparam int KW  = $clog2(FORMANTS + 1);
   localparam int JW  = IW + 1;
   localparam int TD  = MEM_LATENCY;

   localparam logic [BIT_WIDTH-1:0] INF    = '1;
   localparam logic signed [JW-1:0] J_ONE  = 1;
   localparam logic signed [JW-1:0] J_TWO  = 2;
   localparam logic signed [JW-1:0] J_NEG1 = -1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   typedef struct packed {
      logic                 vld;
      logic [KW-1:0]        k;
      logic signed [JW-1:0] j;
      logic                 first;
      logic                 last;
   } tag_t;

   // Row k scans j from k-2 (which is -1 for k=1) up to i-1.
   function automatic logic signed [JW-1:0] start_j(input logic [KW-1:0] k);
      return $signed(JW'(k)) - J_TWO;
   endfunction

   state_t               state_q, state_d;
   logic [IW-1:0]        i_q, i_d;
   logic [KW-1:0]        kl_q, kl_d;
   logic [KW-1:0]        k_q, k_d;
   logic signed [JW-1:0] j_q, j_d;
   tag_t                 tag_q [TD];
   tag_t                 tag_d [TD];
   logic [BIT_WIDTH-1:0] acc_q, acc_d;
   logic signed [JW-1:0] bp_q, bp_d;
   logic                 out_vld_q, out_vld_d;
   logic [KW-1:0]        k_wr_q, k_wr_d;
   logic [BIT_WIDTH-1:0] f_q, f_d;
   logic signed [JW-1:0] b_q, b_d;
   logic                 done_q, done_d;

   logic                 req_vld;
   logic                 row_first;
   logic                 row_last;
   logic signed [JW-1:0] last_j;
   logic [KW-1:0]        kmax_eff;
   logic [IW1-1:0]       i_plus1;
   logic [KW-1:0]        kl_new;
   tag_t                 tag_in;
   tag_t                 ct;
   logic [BIT_WIDTH-1:0] sum;
   logic [BIT_WIDTH-1:0] cost;
   logic                 take;
   logic [BIT_WIDTH-1:0] new_acc;
   logic signed [JW-1:0] new_bp;

   // Row count is min(i+1, k_max), with k_max=0 read as 1.
   assign kmax_eff = (k_max == '0) ? KW'(1) : k_max;
   assign i_plus1  = {1'b0, i} + IW1'(1);
   assign kl_new   = (i_plus1 < IW1'(kmax_eff)) ? KW'(i_plus1) : kmax_eff;

   assign last_j    = $signed({1'b0, i_q}) - J_ONE;
   assign row_last  = (j_q == last_j);
   assign row_first = (j_q == start_j(k_q));

   // Sequencer: walks (k, j) one request per cycle and hops straight into the next row.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      kl_d    = kl_q;
      k_d     = k_q;
      j_d     = j_q;
      req_vld = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (begin_iter) begin
               i_d     = i;
               kl_d    = kl_new;
               k_d     = KW'(1);
               j_d     = J_NEG1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            req_vld = 1'b1;
            if (row_last) begin
               if (k_q < kl_q) begin
                  k_d = k_q + KW'(1);
                  j_d = start_j(k_q + KW'(1));
               end else begin
                  state_d = S_DRAIN;
               end
            end else begin
               j_d = j_q + J_ONE;
            end
         end
         S_DRAIN: begin
            if (done_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request tag travels alongside the memory access so it lines up with e_prev/f_prev.
   always_comb begin
      tag_in       = '0;
      tag_in.vld   = req_vld;
      tag_in.k     = k_q;
      tag_in.j     = j_q;
      tag_in.first = row_first;
      tag_in.last  = row_last;
      tag_d[0]     = tag_in;
      for (int n = 1; n < TD; n++) tag_d[n] = tag_q[n-1];
   end

   assign ct = tag_q[TD-1];

`ifdef FDP_SAT_EN
   logic [BIT_WIDTH:0] sum_w;
   assign sum_w = {1'b0, e_prev} + {1'b0, f_prev};
   assign sum   = sum_w[BIT_WIDTH] ? INF : sum_w[BIT_WIDTH-1:0];
`else
   assign sum = e_prev + f_prev;
`endif

   // Cost of the candidate arriving now, then running min with strict compare so the lowest j keeps ties.
   always_comb begin
      cost = sum;
      if (ct.j == J_NEG1) begin
         cost = (ct.k == KW'(1)) ? e_prev : INF;
      end else if ((e_prev == INF) || (f_prev == INF)) begin
         cost = INF;
      end
      take    = ct.first || (cost < acc_q);
      new_acc = take ? cost : acc_q;
      new_bp  = take ? ct.j : bp_q;

      acc_d     = ct.vld ? new_acc : acc_q;
      bp_d      = ct.vld ? new_bp : bp_q;
      out_vld_d = ct.vld && ct.last;
      k_wr_d    = out_vld_d ? ct.k : k_wr_q;
      f_d       = out_vld_d ? new_acc : f_q;
      b_d       = out_vld_d ? new_bp : b_q;
      done_d    = out_vld_d && (ct.k == kl_q);
   end

   // All state; reset discards anything in flight.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= S_IDLE;
         i_q       <= '0;
         kl_q      <= '0;
         k_q       <= '0;
         j_q       <= '0;
         for (int n = 0; n < TD; n++) tag_q[n] <= '0;
         acc_q     <= '0;
         bp_q      <= '0;
         out_vld_q <= 1'b0;
         k_wr_q    <= '0;
         f_q       <= '0;
         b_q       <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         kl_q      <= kl_d;
         k_q       <= k_d;
         j_q       <= j_d;
         tag_q     <= tag_d;
         acc_q     <= acc_d;
         bp_q      <= bp_d;
         out_vld_q <= out_vld_d;
         k_wr_q    <= k_wr_d;
         f_q       <= f_d;
         b_q       <= b_d;
         done_q    <= done_d;
      end
   end

   assign req_valid    = req_vld;
   assign k_req        = req_vld ? k_q : '0;
   assign j_req        = req_vld ? j_q : '0;
   assign output_valid = out_vld_q;
   assign k_write      = k_wr_q;
   assign f_data       = f_q;
   assign b_data       = b_q;
   assign busy         = (state_q != S_IDLE);
   assign iter_done    = done_q;

endmodule
